// File: rtl/chunk_hasher_pkg.sv
// BLAKE3 constants, state types and the G mixing primitive for the chunk hasher.
// Pure definitions: no latency and no flow control of its own.
package chunk_hasher_pkg;

    typedef logic [15:0][31:0] state_t;
    typedef logic [15:0][31:0] msg_t;
    typedef logic [7:0][31:0]  cv_t;

    typedef enum logic {
        ST_IDLE,
        ST_ROUNDS
    } fsm_e;

    localparam logic [31:0] IV_0 = 32'h6A09E667;
    localparam logic [31:0] IV_1 = 32'hBB67AE85;
    localparam logic [31:0] IV_2 = 32'h3C6EF372;
    localparam logic [31:0] IV_3 = 32'hA54FF53A;
    localparam logic [31:0] IV_4 = 32'h510E527F;
    localparam logic [31:0] IV_5 = 32'h9B05688C;
    localparam logic [31:0] IV_6 = 32'h1F83D9AB;
    localparam logic [31:0] IV_7 = 32'h5BE0CD19;
    localparam cv_t IV = {IV_7, IV_6, IV_5, IV_4, IV_3, IV_2, IV_1, IV_0};

    localparam logic [3:0] MSG_PERM [16] = '{4'd2, 4'd6, 4'd3, 4'd10, 4'd7, 4'd0, 4'd4, 4'd13,
                                             4'd1, 4'd11, 4'd12, 4'd5, 4'd9, 4'd14, 4'd15, 4'd8};

    localparam logic [31:0] CHUNK_START = 32'h0000_0001;
    localparam logic [31:0] CHUNK_END   = 32'h0000_0002;
    localparam logic [31:0] ROOT        = 32'h0000_0008;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Returns the mixed quadruple packed as {d, c, b, a}.
    function automatic logic [127:0] g_mix(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c, input logic [31:0] d,
                                           input logic [31:0] mx, input logic [31:0] my);
        logic [31:0] a1, b1, c1, d1;
        a1 = a + b + mx;
        d1 = rotr(d ^ a1, 16);
        c1 = c + d1;
        b1 = rotr(b ^ c1, 12);
        a1 = a1 + b1 + my;
        d1 = rotr(d1 ^ a1, 8);
        c1 = c1 + d1;
        b1 = rotr(b1 ^ c1, 7);
        return {d1, c1, b1, a1};
    endfunction

    // Counter is always 0: this block only ever hashes chunk 0.
    function automatic state_t init_state(input cv_t h, input logic [6:0] blen,
                                          input logic [31:0] flags);
        state_t v;
        v[7:0]  = h;
        v[11:8] = IV[3:0];
        v[12]   = 32'd0;
        v[13]   = 32'd0;
        v[14]   = {25'd0, blen};
        v[15]   = flags;
        return v;
    endfunction

endpackage

// File: rtl/chunk_hasher_round.sv
// One full BLAKE3 round (column then diagonal G mixes) plus the permuted message schedule.
// Purely combinational; no flow control.
module chunk_hasher_round
    import chunk_hasher_pkg::*;
(
    input  state_t v_i,
    input  msg_t   m_i,
    output state_t v_o,
    output msg_t   m_o
);

    state_t col;
    state_t dia;

    always_comb begin
        col = v_i;
        {col[12], col[8], col[4], col[0]} = g_mix(v_i[0], v_i[4], v_i[8],  v_i[12], m_i[0], m_i[1]);
        {col[13], col[9], col[5], col[1]} = g_mix(v_i[1], v_i[5], v_i[9],  v_i[13], m_i[2], m_i[3]);
        {col[14], col[10], col[6], col[2]} = g_mix(v_i[2], v_i[6], v_i[10], v_i[14], m_i[4], m_i[5]);
        {col[15], col[11], col[7], col[3]} = g_mix(v_i[3], v_i[7], v_i[11], v_i[15], m_i[6], m_i[7]);

        dia = col;
        {dia[15], dia[10], dia[5], dia[0]} = g_mix(col[0], col[5], col[10], col[15], m_i[8],  m_i[9]);
        {dia[12], dia[11], dia[6], dia[1]} = g_mix(col[1], col[6], col[11], col[12], m_i[10], m_i[11]);
        {dia[13], dia[8],  dia[7], dia[2]} = g_mix(col[2], col[7], col[8],  col[13], m_i[12], m_i[13]);
        {dia[14], dia[9],  dia[4], dia[3]} = g_mix(col[3], col[4], col[9],  col[14], m_i[14], m_i[15]);
    end

    assign v_o = dia;

    for (genvar i = 0; i < 16; i++) begin : g_perm
        assign m_o[i] = m_i[MSG_PERM[i]];
    end

endmodule

// File: rtl/chunk_hasher.sv
// Single-chunk BLAKE3 root hasher: 8 cycles per 64-byte block (7 rounds + feed-forward).
// No backpressure: the feeder must present the block at Addr_O before the next block boundary.
module chunk_hasher
    import chunk_hasher_pkg::*;
(
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Update_I,
    input  logic [15:0][31:0] Msg_I,
    input  logic [31:0]      Byte_num_I,
    output logic [9:0]       Addr_O,
    output logic [7:0][31:0] H_O,
    output logic             Vld_O
);

    fsm_e       state_q, state_d;
    logic [2:0] rnd_q, rnd_d;
    logic [3:0] blk_q, blk_d;
    logic [3:0] nlast_q, nlast_d;
    logic [6:0] lastlen_q, lastlen_d;
    logic [9:0] addr_q, addr_d;
    logic       vld_q, vld_d;
    cv_t        h_q, h_d;
    state_t     v_q, v_d;
    msg_t       m_q, m_d;

    state_t     rnd_v;
    msg_t       rnd_m;
    cv_t        ff;

    logic       up_zero;
    logic [9:0] up_lm1;
    logic [3:0] up_nlast;
    logic [6:0] up_lastlen;
    logic [3:0] nxt_blk;
    logic       nxt_last;

    chunk_hasher_round u_round (
        .v_i (v_q),
        .m_i (m_q),
        .v_o (rnd_v),
        .m_o (rnd_m)
    );

    assign ff = v_q[7:0] ^ v_q[15:8];

    // Lengths are clamped to one chunk; (len-1) splits into last-block index and tail size.
    assign up_zero    = (Byte_num_I == 32'd0);
    assign up_lm1     = (Byte_num_I >= 32'd1024) ? 10'd1023 : (Byte_num_I[9:0] - 10'd1);
    assign up_nlast   = up_zero ? 4'd0 : up_lm1[9:6];
    assign up_lastlen = up_zero ? 7'd0 : ({1'b0, up_lm1[5:0]} + 7'd1);
    assign nxt_blk    = blk_q + 4'd1;
    assign nxt_last   = (nxt_blk == nlast_q);

    always_comb begin
        state_d   = state_q;
        rnd_d     = rnd_q;
        blk_d     = blk_q;
        nlast_d   = nlast_q;
        lastlen_d = lastlen_q;
        addr_d    = addr_q;
        vld_d     = vld_q;
        h_d       = h_q;
        v_d       = v_q;
        m_d       = m_q;
        case (state_q)
            ST_IDLE: begin
                if (Update_I) begin
                    state_d   = ST_ROUNDS;
                    rnd_d     = 3'd0;
                    blk_d     = 4'd0;
                    nlast_d   = up_nlast;
                    lastlen_d = up_lastlen;
                    addr_d    = 10'd64;
                    vld_d     = 1'b0;
                    h_d       = IV;
                    v_d       = init_state(IV, (up_nlast == 4'd0) ? up_lastlen : 7'd64,
                                           CHUNK_START | ((up_nlast == 4'd0) ? (CHUNK_END | ROOT) : 32'd0));
                    m_d       = Msg_I;
                end
            end
            ST_ROUNDS: begin
                if (rnd_q != 3'd7) begin
                    v_d   = rnd_v;
                    m_d   = rnd_m;
                    rnd_d = rnd_q + 3'd1;
                end else if (blk_q == nlast_q) begin
                    h_d     = ff;
                    vld_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    h_d    = ff;
                    blk_d  = nxt_blk;
                    addr_d = addr_q + 10'd64;
                    rnd_d  = 3'd0;
                    v_d    = init_state(ff, nxt_last ? lastlen_q : 7'd64,
                                        nxt_last ? (CHUNK_END | ROOT) : 32'd0);
                    m_d    = Msg_I;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= ST_IDLE;
            rnd_q     <= 3'd0;
            blk_q     <= 4'd0;
            nlast_q   <= 4'd0;
            lastlen_q <= 7'd0;
            addr_q    <= 10'd0;
            vld_q     <= 1'b0;
            h_q       <= '0;
            v_q       <= '0;
            m_q       <= '0;
        end else begin
            state_q   <= state_d;
            rnd_q     <= rnd_d;
            blk_q     <= blk_d;
            nlast_q   <= nlast_d;
            lastlen_q <= lastlen_d;
            addr_q    <= addr_d;
            vld_q     <= vld_d;
            h_q       <= h_d;
            v_q       <= v_d;
            m_q       <= m_d;
        end
    end

    assign Addr_O = addr_q;
    assign H_O    = h_q;
    assign Vld_O  = vld_q;

endmodule

// File: tb/tb_chunk_hasher.sv
// Directed sequence of chunk hashes with random block data, checked against a BLAKE3 model.
module tb_chunk_hasher;

    logic              Clk;
    logic              Rst;
    logic              Update_I;
    logic [15:0][31:0] Msg_I;
    logic [31:0]       Byte_num_I;
    logic [9:0]        Addr_O;
    logic [7:0][31:0]  H_O;
    logic              Vld_O;

    int checks = 0;
    int errors = 0;

    bit [31:0]        blk_mem [16][16];
    logic [7:0][31:0] ref_h;

    localparam bit [31:0] TIV [8] = '{32'h6A09E667, 32'hBB67AE85, 32'h3C6EF372, 32'hA54FF53A,
                                      32'h510E527F, 32'h9B05688C, 32'h1F83D9AB, 32'h5BE0CD19};
    localparam int GIDX [8][4] = '{'{0, 4, 8, 12}, '{1, 5, 9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
                                   '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7, 8, 13}, '{3, 4, 9, 14}};
    localparam int PERM [16] = '{2, 6, 3, 10, 7, 0, 4, 13, 1, 11, 12, 5, 9, 14, 15, 8};

    chunk_hasher dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Update_I   (Update_I),
        .Msg_I      (Msg_I),
        .Byte_num_I (Byte_num_I),
        .Addr_O     (Addr_O),
        .H_O        (H_O),
        .Vld_O      (Vld_O)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit [31:0] ror(input bit [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Digest bytes in printed order -> little-endian words h0..h7.
    function automatic logic [7:0][31:0] digest_to_h(input logic [255:0] d);
        logic [7:0][31:0] r;
        logic [31:0] w;
        for (int i = 0; i < 8; i++) begin
            w    = d[255 - 32*i -: 32];
            r[i] = {w[7:0], w[15:8], w[23:16], w[31:24]};
        end
        return r;
    endfunction

    task automatic fill_random(input int len);
        int eff;
        bit [31:0] w;
        eff = (len > 1024) ? 1024 : len;
        for (int bk = 0; bk < 16; bk++)
            for (int wi = 0; wi < 16; wi++) begin
                w = $urandom;
                for (int bt = 0; bt < 4; bt++)
                    if (64*bk + 4*wi + bt >= eff) w[8*bt +: 8] = 8'h00;
                blk_mem[bk][wi] = w;
            end
    endtask

    task automatic clear_blocks();
        for (int bk = 0; bk < 16; bk++)
            for (int wi = 0; wi < 16; wi++) blk_mem[bk][wi] = 32'h0;
    endtask

    // Reference: chunk hash from the algorithm description, using a precomputed word schedule.
    task automatic ref_hash(input int len);
        int eff, n, blen, a, b, c, d;
        int sidx [16];
        int tmp [16];
        bit [31:0] cv [8];
        bit [31:0] v [16];
        bit [31:0] fl;
        eff = (len > 1024) ? 1024 : len;
        n   = (eff == 0) ? 1 : (eff + 63) / 64;
        for (int i = 0; i < 8; i++) cv[i] = TIV[i];
        for (int bk = 0; bk < n; bk++) begin
            blen = (bk == n - 1) ? eff - 64*(n - 1) : 64;
            fl = 32'h0;
            if (bk == 0)     fl = fl | 32'h01;
            if (bk == n - 1) fl = fl | 32'h0A;
            for (int i = 0; i < 8; i++) v[i] = cv[i];
            for (int i = 0; i < 4; i++) v[8 + i] = TIV[i];
            v[12] = 32'h0;
            v[13] = 32'h0;
            v[14] = blen;
            v[15] = fl;
            for (int i = 0; i < 16; i++) sidx[i] = i;
            for (int r = 0; r < 7; r++) begin
                for (int gq = 0; gq < 8; gq++) begin
                    a = GIDX[gq][0]; b = GIDX[gq][1]; c = GIDX[gq][2]; d = GIDX[gq][3];
                    v[a] = v[a] + v[b] + blk_mem[bk][sidx[2*gq]];
                    v[d] = ror(v[d] ^ v[a], 16);
                    v[c] = v[c] + v[d];
                    v[b] = ror(v[b] ^ v[c], 12);
                    v[a] = v[a] + v[b] + blk_mem[bk][sidx[2*gq + 1]];
                    v[d] = ror(v[d] ^ v[a], 8);
                    v[c] = v[c] + v[d];
                    v[b] = ror(v[b] ^ v[c], 7);
                end
                for (int i = 0; i < 16; i++) tmp[i] = sidx[PERM[i]];
                sidx = tmp;
            end
            for (int i = 0; i < 8; i++) cv[i] = v[i] ^ v[i + 8];
        end
        for (int i = 0; i < 8; i++) ref_h[i] = cv[i];
    endtask

    task automatic present(input int k);
        for (int i = 0; i < 16; i++) Msg_I[i] = (k < 16) ? blk_mem[k][i] : 32'h0;
    endtask

    // Runs one chunk from the current blk_mem; poke>0 pulses Update_I at that cycle.
    task automatic run_chunk(input int len, input string tag, input int poke);
        int eff, n, cyc, steps, exp_addr;
        eff = (len > 1024) ? 1024 : len;
        n   = (eff == 0) ? 1 : (eff + 63) / 64;
        ref_hash(len);
        present(0);
        Byte_num_I = len;
        Update_I   = 1'b1;
        @(posedge Clk); #1;
        Update_I = 1'b0;
        chk({tag, "_vld_drop"}, 256'(Vld_O), 256'(1'b0));
        chk({tag, "_addr_first"}, 256'(Addr_O), 256'(10'd64));
        cyc = 0;
        while (!Vld_O && cyc < 200) begin
            present(int'(Addr_O) / 64);
            if (poke > 0 && cyc == poke) begin
                Update_I   = 1'b1;
                Byte_num_I = 32'd7;
            end
            @(posedge Clk); #1;
            Update_I = 1'b0;
            cyc++;
            steps    = (cyc / 8 < n - 1) ? cyc / 8 : n - 1;
            exp_addr = (64 * (1 + steps)) % 1024;
            if (cyc % 8 == 0) chk({tag, "_addr"}, 256'(Addr_O), 256'(exp_addr));
        end
        chk({tag, "_latency"}, 256'(cyc), 256'(8 * n));
        chk({tag, "_vld"}, 256'(Vld_O), 256'(1'b1));
        chk({tag, "_hash"}, H_O, ref_h);
    endtask

    initial begin
        logic [9:0] held_addr;
        Rst        = 1'b1;
        Update_I   = 1'b0;
        Msg_I      = '0;
        Byte_num_I = 32'd0;
        repeat (2) @(posedge Clk);
        #1;
        chk("reset_addr", 256'(Addr_O), 256'(10'd0));
        chk("reset_h", H_O, 256'd0);
        chk("reset_vld", 256'(Vld_O), 256'(1'b0));
        Rst = 1'b0;
        @(posedge Clk); #1;

        clear_blocks();
        run_chunk(0, "empty", 0);
        chk("empty_h0", 256'(H_O[0]), 256'(32'hb94913af));
        chk("empty_digest", H_O,
            digest_to_h(256'haf1349b9f5f9a1a6a0404dea36dcc9499bcb25c9adc112b7cc9a93cae41f3262));

        clear_blocks();
        blk_mem[0][0] = 32'h00636261;
        run_chunk(3, "abc", 0);
        chk("abc_digest", H_O,
            digest_to_h(256'h6437b3ac38465133ffb63b75273a8db548c558465d79db03fd359c6cd5bd9d85));

        fill_random(64);
        run_chunk(64, "len64", 0);
        fill_random(65);
        run_chunk(65, "len65", 0);

        held_addr = Addr_O;
        repeat (5) begin
            Msg_I = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                     $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            @(posedge Clk); #1;
        end
        chk("hold_vld", 256'(Vld_O), 256'(1'b1));
        chk("hold_hash", H_O, ref_h);
        chk("hold_addr", 256'(Addr_O), 256'(held_addr));

        fill_random(1024);
        run_chunk(1024, "len1024", 0);
        fill_random(5000);
        run_chunk(5000, "clamp5000", 0);

        for (int t = 0; t < 4; t++) begin
            int len;
            len = $urandom_range(1, 1024);
            fill_random(len);
            run_chunk(len, "rand", 0);
        end

        fill_random(200);
        run_chunk(200, "busy_update", 11);

        fill_random(300);
        present(0);
        Byte_num_I = 32'd300;
        Update_I   = 1'b1;
        @(posedge Clk); #1;
        Update_I = 1'b0;
        repeat (13) begin
            present(int'(Addr_O) / 64);
            @(posedge Clk); #1;
        end
        Rst = 1'b1;
        @(posedge Clk); #1;
        Rst = 1'b0;
        chk("midrst_vld", 256'(Vld_O), 256'(1'b0));
        chk("midrst_addr", 256'(Addr_O), 256'(10'd0));
        chk("midrst_h", H_O, 256'd0);
        run_chunk(300, "after_rst", 0);

        fill_random(130);
        run_chunk(130, "b2b_first", 0);
        fill_random(17);
        run_chunk(17, "b2b_second", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/chunk_hasher.md
# chunk_hasher

Single-chunk BLAKE3 compressor for the miner datapath. It accepts one chunk of up to 1024 bytes as a sequence of 64-byte message blocks and chains the compression function across them. It then outputs the 256-bit root hash of that chunk (flags CHUNK_START / CHUNK_END / ROOT, counter 0, key = IV). The upstream block feeder supplies message blocks; the nonce/target comparison logic consumes the hash.

## Interface
Parameters: none; IV, flags and message permutation are package constants.
- Clk  in  1  rising-edge clock; sole clock domain.
- Rst  in  1  synchronous, active-high reset.
- Update_I  in  1  1-cycle start pulse; ignored unless idle (not busy).
- Msg_I  in  16x32  current block; Msg_I[i] = message word m[i], little-endian word value of bytes 4i..4i+3.
- Byte_num_I  in  32  chunk length in bytes; sampled with Update_I.
- Addr_O  out  10  byte offset of the next block the feeder must present on Msg_I.
- H_O  out  8x32  chaining value / final hash words h0..h7.
- Vld_O  out  1  high when H_O holds the finished chunk hash.

## Operation
- Reset: Addr_O=0, H_O=0, Vld_O=0, state IDLE.
- IDLE + Update_I: latch Msg_I as block 0, latch len=min(Byte_num_I,1024), h=IV, Vld_O←0, Addr_O←64, enter ROUNDS.
- Block count n = max(1, ceil(len/64)). block_len = 64 for blocks 0..n-2; last = len−64(n−1) (0 for len=0).
- Per block, state v = {h0..h7, IV0..IV3, t_lo=0, t_hi=0, block_len, flags}.
  - flags: CHUNK_START(0x01) on block 0; CHUNK_END(0x02)|ROOT(0x08) on block n−1; both when n=1.
  - 7 BLAKE3 rounds with the standard message permutation between rounds.
  - Feed-forward h'[i] = v[i]^v[i+8].
- Non-last block: h←h'; latch Msg_I as next block; Addr_O += 64 (10-bit wrap: 1024→0); start next block's rounds.
- Last block: H_O←h', Vld_O←1, return IDLE. H_O, Vld_O and Addr_O hold until the next Update_I.
- Update_I while busy: ignored. Rst mid-operation: immediate return to reset values.
- Trailing bytes beyond len in the last block: the feeder zero-fills them; the DUT does not mask.

## Timing
- One full round (8 G functions) per cycle.
- Edge 0 samples Update_I; rounds on edges 1..7; feed-forward at edge 8.
- Block k latched at edge 8k. Addr_O changes at edge 0 and at edges 8, 16, …, 8(n−1).
- Msg_I must be stable on the edge after Addr_O changes, and within 7 cycles of it.
- Vld_O rises at edge 8n; 1-block chunk: 8 cycles; 16 blocks: 128 cycles.
- Back-to-back chunks: Update_I accepted in the cycle after Vld_O rises.

## Structure
- Package (defines): IV_0..IV_7, MSG_PERM[16], flag constants CHUNK_START/CHUNK_END/ROOT, 16x32 state typedef.
- One sub-module RoundFunction: combinational one round (columns then diagonals, rotations 16/12/8/7) plus permuted message output.
- Top: FSM (IDLE/ROUNDS), round counter 0..6, block counter, Addr_O register, v/h/message registers.

## Test plan
- Empty chunk: Byte_num_I=0, Msg_I=0 → after 8 cycles Vld_O=1, H_O[0]=0xb94913af; byte-swapped concatenation = af1349b9f5f9a1a6a0404dea36dcc9499bcb25c9adc112b7cc9a93cae41f3262.
- "abc": Msg_I[0]=0x00636261, others 0, Byte_num_I=3 → hash 6437b3ac38465133ffb63b75273a8db548c558465d79db03fd359c6cd5bd9d85.
- 1024-byte chunk, 16 blocks fed on each Addr_O change:
  - Addr_O steps 64,128,…,960, then wraps to 0.
  - Vld_O at cycle 128.
  - H_O matches the BLAKE3 reference model.
- Length 65 (2 blocks, last block_len=1) and length 64 (1 block) → match reference model; Vld_O at 16 and 8 cycles respectively.
- Update_I pulsed mid-chunk → ignored, result unchanged. Rst asserted mid-chunk → Vld_O=0, Addr_O=0, H_O=0 next cycle; a fresh chunk afterwards hashes correctly.
- Two chunks back-to-back (second Update_I while Vld_O=1) → Vld_O drops, second hash correct.
